// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: packs big-endian bytes into 32-bit words and writes WORDS of them from BASE_ADDR.
// Define IMEM_LOADER_CHECKSUM_EN to add the 32-bit running checksum output.
//
// state   | meaning
// IDLE    | waiting for start after reset
// COLLECT | accepting bytes of the current word
// WRITE   | one-cycle write strobe for the assembled word
// DONE    | load finished, waiting for start
module imem_loader #(
  parameter int unsigned WORDS     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam logic [15:0] WORDS_L = 16'(WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [15:0] count_q;
  logic [15:0] count_inc;
  logic [1:0]  byte_idx_q;
  logic        accept;
  logic        launch;

  assign accept    = (state_q == COLLECT) && in_valid;
  assign launch    = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign count_inc = count_q + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = COLLECT;
      end
      COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (byte_idx_q == 2'd3)) state_d = WRITE;
      end
      WRITE: begin
        wr_en   = 1'b1;
        busy    = 1'b1;
        state_d = (count_inc == WORDS_L) ? DONE : COLLECT;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = COLLECT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shifting in from the bottom leaves the first byte in [31:24] after four accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      count_q    <= 16'd0;
      byte_idx_q <= 2'd0;
    end else begin
      if (launch) begin
        addr_q     <= BASE_ADDR;
        count_q    <= 16'd0;
        byte_idx_q <= 2'd0;
      end
      if (accept) begin
        data_q     <= {data_q[23:0], in_data};
        byte_idx_q <= byte_idx_q + 2'd1;
      end
      if (state_q == WRITE) begin
        addr_q  <= addr_q + 32'd4;
        count_q <= count_inc;
      end
    end
  end

  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign word_count = count_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= 32'd0;
    end else if (launch) begin
      sum_q <= 32'd0;
    end else if (state_q == WRITE) begin
      sum_q <= sum_q + data_q;
    end
  end

  assign checksum = sum_q;
`endif

endmodule
